// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/forward controller for a 5-stage RISC-V pipe.
//   clk_i, rst_i             clock, synchronous active-high reset
//   rs*/rd*/RegWrite*/use*   register ids and qualifiers from ID, EX, MEM, WB
//   MemRead_EX_i             EX holds a load (load-use detection)
//   PCsrc_MEM_i              non-zero: redirect resolved in MEM
//   dmemReq_i/dmemReady_i    data memory handshake; req & ~ready = wait
//   ForwardAE_o/ForwardBE_o  EX operand selects: 00 regfile, 10 MEM, 01 WB
//   stall*/freeze/flush*/killWB  combinational pipe controls
//   mem_err_o                sticky memory-timeout error (registered)
//   stallCnt_o/flushCnt_o    saturating performance counters (registered)
module pipe_hazard_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       rs1_ID_i,
  input  logic [4:0]       rs2_ID_i,
  input  logic             useRs1_ID_i,
  input  logic             useRs2_ID_i,
  input  logic [4:0]       rs1_EX_i,
  input  logic [4:0]       rs2_EX_i,
  input  logic [4:0]       rd_EX_i,
  input  logic             MemRead_EX_i,
  input  logic [4:0]       rd_MEM_i,
  input  logic             RegWrite_MEM_i,
  input  logic [4:0]       rd_WB_i,
  input  logic             RegWrite_WB_i,
  input  logic [1:0]       PCsrc_MEM_i,
  input  logic             dmemReq_i,
  input  logic             dmemReady_i,
  output logic [1:0]       ForwardAE_o,
  output logic [1:0]       ForwardBE_o,
  output logic             stallIF_o,
  output logic             stallID_o,
  output logic             freeze_o,
  output logic             flushID_o,
  output logic             flushEX_o,
  output logic             flushMEM_o,
  output logic             killWB_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stallCnt_o,
  output logic [CNT_W-1:0] flushCnt_o
);

  localparam int unsigned WAIT_W = 8;

  typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_ERR} state_t;

  state_t            r_state, w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic              r_mem_err;
  logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt;

  logic w_mem_wait, w_load_use, w_redirect;
  logic w_stall, w_freeze, w_kill, w_flush_id, w_flush_ex, w_flush_mem;

  // Operand forwarding; MEM wins over WB, x0 never forwarded
  always_comb begin
    ForwardAE_o = 2'b00;
    ForwardBE_o = 2'b00;
    if (RegWrite_MEM_i && (rd_MEM_i != 5'd0) && (rd_MEM_i == rs1_EX_i))
      ForwardAE_o = 2'b10;
    else if (RegWrite_WB_i && (rd_WB_i != 5'd0) && (rd_WB_i == rs1_EX_i))
      ForwardAE_o = 2'b01;
    if (RegWrite_MEM_i && (rd_MEM_i != 5'd0) && (rd_MEM_i == rs2_EX_i))
      ForwardBE_o = 2'b10;
    else if (RegWrite_WB_i && (rd_WB_i != 5'd0) && (rd_WB_i == rs2_EX_i))
      ForwardBE_o = 2'b01;
  end

  assign w_mem_wait = dmemReq_i & ~dmemReady_i;
  assign w_redirect = |PCsrc_MEM_i;
  assign w_load_use = MemRead_EX_i && (rd_EX_i != 5'd0) &&
                      ((useRs1_ID_i && (rs1_ID_i == rd_EX_i)) ||
                       (useRs2_ID_i && (rs2_ID_i == rd_EX_i)));

  // Next state and pipe controls; priority ERR > memWait > redirect > load-use
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_stall        = 1'b0;
    w_freeze       = 1'b0;
    w_kill         = 1'b0;
    w_flush_id     = 1'b0;
    w_flush_ex     = 1'b0;
    w_flush_mem    = 1'b0;
    if (!rst_i) begin
      case (r_state)
        S_RUN, S_MEM_WAIT: begin
          if (w_mem_wait) begin
            w_stall  = 1'b1;
            w_freeze = 1'b1;
            w_kill   = 1'b1;
            // Counter holds the number of consecutive wait cycles seen
            w_wait_cnt_nxt = (r_state == S_MEM_WAIT) ? r_wait_cnt + WAIT_W'(1)
                                                     : WAIT_W'(1);
            w_state_nxt = (w_wait_cnt_nxt == WAIT_W'(MEM_TIMEOUT)) ? S_ERR
                                                                   : S_MEM_WAIT;
          end else begin
            // Ready cycle of a wait behaves exactly like RUN
            w_state_nxt    = S_RUN;
            w_wait_cnt_nxt = '0;
            if (w_redirect) begin
              w_flush_id  = 1'b1;
              w_flush_ex  = 1'b1;
              w_flush_mem = 1'b1;
            end else if (w_load_use) begin
              w_stall    = 1'b1;
              w_flush_ex = 1'b1;
            end
          end
        end
        default: begin
          w_stall  = 1'b1;
          w_freeze = 1'b1;
          w_kill   = 1'b1;
        end
      endcase
    end
  end

  // State, sticky error and saturating counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_RUN;
      r_wait_cnt  <= '0;
      r_mem_err   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_state_nxt == S_ERR)
        r_mem_err <= 1'b1;
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_mem && (r_flush_cnt != {CNT_W{1'b1}}))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stallIF_o  = w_stall;
  assign stallID_o  = w_stall;
  assign freeze_o   = w_freeze;
  assign killWB_o   = w_kill;
  assign flushID_o  = w_flush_id;
  assign flushEX_o  = w_flush_ex;
  assign flushMEM_o = w_flush_mem;
  assign mem_err_o  = r_mem_err;
  assign stallCnt_o = r_stall_cnt;
  assign flushCnt_o = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic against
// a cycle-level reference model of the hazard rules.
module tb_pipe_hazard_ctrl;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned TIMEOUT = 4;
  localparam int          CMAX    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1_ID, rs2_ID, rs1_EX, rs2_EX, rd_EX, rd_MEM, rd_WB;
  logic useRs1_ID, useRs2_ID, MemRead_EX, RegWrite_MEM, RegWrite_WB;
  logic [1:0] PCsrc;
  logic dmemReq, dmemReady;
  logic [1:0] ForwardAE, ForwardBE;
  logic stallIF, stallID, freeze, flushID, flushEX, flushMEM, killWB, mem_err;
  logic [CNT_W-1:0] stallCnt, flushCnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit m_err;
  int m_waitc, m_scnt, m_fcnt;
  bit m_stall, m_redir, m_mw;
  logic [19:0] exp_vec, obs_vec;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst),
    .rs1_ID_i(rs1_ID), .rs2_ID_i(rs2_ID),
    .useRs1_ID_i(useRs1_ID), .useRs2_ID_i(useRs2_ID),
    .rs1_EX_i(rs1_EX), .rs2_EX_i(rs2_EX), .rd_EX_i(rd_EX),
    .MemRead_EX_i(MemRead_EX),
    .rd_MEM_i(rd_MEM), .RegWrite_MEM_i(RegWrite_MEM),
    .rd_WB_i(rd_WB), .RegWrite_WB_i(RegWrite_WB),
    .PCsrc_MEM_i(PCsrc), .dmemReq_i(dmemReq), .dmemReady_i(dmemReady),
    .ForwardAE_o(ForwardAE), .ForwardBE_o(ForwardBE),
    .stallIF_o(stallIF), .stallID_o(stallID), .freeze_o(freeze),
    .flushID_o(flushID), .flushEX_o(flushEX), .flushMEM_o(flushMEM),
    .killWB_o(killWB), .mem_err_o(mem_err),
    .stallCnt_o(stallCnt), .flushCnt_o(flushCnt)
  );

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (RegWrite_MEM && rd_MEM != 0 && rd_MEM == rs) return 2'b10;
    if (RegWrite_WB && rd_WB != 0 && rd_WB == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic set_idle();
    rst = 0; rs1_ID = 0; rs2_ID = 0; useRs1_ID = 0; useRs2_ID = 0;
    rs1_EX = 0; rs2_EX = 0; rd_EX = 0; MemRead_EX = 0;
    rd_MEM = 0; RegWrite_MEM = 0; rd_WB = 0; RegWrite_WB = 0;
    PCsrc = 0; dmemReq = 0; dmemReady = 0;
  endtask

  // Settle at the falling edge, compute expected outputs from the model
  task automatic eval_cycle();
    logic st, fr, fi, fe, fm, kl, lu;
    @(negedge clk);
    m_mw = dmemReq && !dmemReady;
    lu = MemRead_EX && rd_EX != 0 &&
         ((useRs1_ID && rs1_ID == rd_EX) || (useRs2_ID && rs2_ID == rd_EX));
    {st, fr, fi, fe, fm, kl} = '0;
    m_redir = 0;
    if (!rst) begin
      if (m_err || m_mw) begin st = 1; fr = 1; kl = 1; end
      else if (PCsrc != 0) begin fi = 1; fe = 1; fm = 1; m_redir = 1; end
      else if (lu) begin st = 1; fe = 1; end
    end
    m_stall = st;
    exp_vec = {fwd_ref(rs1_EX), fwd_ref(rs2_EX), st, st, fr, fi, fe, fm, kl,
               m_err, 4'(m_scnt), 4'(m_fcnt)};
    obs_vec = {ForwardAE, ForwardBE, stallIF, stallID, freeze, flushID, flushEX,
               flushMEM, killWB, mem_err, stallCnt, flushCnt};
  endtask

  // Clock edge: advance the model, then release inputs for the next cycle
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_err = 0; m_waitc = 0; m_scnt = 0; m_fcnt = 0;
    end else begin
      if (m_stall && m_scnt < CMAX) m_scnt++;
      if (m_redir && m_fcnt < CMAX) m_fcnt++;
      if (!m_err) begin
        if (m_mw) begin
          m_waitc++;
          if (m_waitc == TIMEOUT) m_err = 1;
        end else m_waitc = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    set_idle(); rst = 1;
    eval_cycle(); tick();
    eval_cycle(); tick();
    rst = 0;
  endtask

  task automatic test_reset();
    set_idle(); rst = 1;
    eval_cycle(); tick();
    // Hazard-provoking inputs held during reset must not produce controls
    dmemReq = 1; PCsrc = 2'b01; MemRead_EX = 1; rd_EX = 5; rs1_ID = 5; useRs1_ID = 1;
    eval_cycle();
    n_cmp++;
    if (obs_vec !== 20'd0) begin
      n_err++; $display("FAIL reset_outputs: got %h expected %h", obs_vec, 20'd0);
    end
    tick();
    set_idle();
    eval_cycle();
    n_cmp++;
    if (obs_vec !== exp_vec || obs_vec !== 20'd0) begin
      n_err++; $display("FAIL reset_release: got %h expected %h", obs_vec, exp_vec);
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    MemRead_EX = 1; rd_EX = 5; rs1_ID = 5; useRs1_ID = 1;
    eval_cycle();
    n_cmp++;
    if ({stallIF, stallID, flushEX, freeze, flushMEM} !== 5'b11100 || obs_vec !== exp_vec) begin
      n_err++; $display("FAIL load_use_stall: got %h expected %h", obs_vec, exp_vec);
    end
    tick();
    set_idle(); rd_MEM = 5; RegWrite_MEM = 1; rs1_EX = 5;
    eval_cycle();
    n_cmp++;
    if (ForwardAE !== 2'b10 || stallIF !== 1'b0 || stallCnt !== 4'd1 || obs_vec !== exp_vec) begin
      n_err++; $display("FAIL load_use_forward: got %h expected %h", obs_vec, exp_vec);
    end
    tick();
  endtask

  task automatic test_forward_priority();
    logic [4:0] rdv [3] = '{5'd7, 5'd0, 5'd3};
    logic [1:0] want [3] = '{2'b10, 2'b00, 2'b01};
    for (int i = 0; i < 3; i++) begin
      set_idle();
      RegWrite_MEM = 1; RegWrite_WB = 1; rs2_EX = rdv[i];
      rd_MEM = rdv[i]; rd_WB = (i == 2) ? 5'd3 : rdv[i];
      if (i == 2) rd_MEM = 5'd9;
      eval_cycle();
      n_cmp++;
      if (ForwardBE !== want[i] || obs_vec !== exp_vec) begin
        n_err++; $display("FAIL forward_b_%0d: got %b expected %b", i, ForwardBE, want[i]);
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    PCsrc = 2'b01; MemRead_EX = 1; rd_EX = 6; rs2_ID = 6; useRs2_ID = 1;
    eval_cycle();
    n_cmp++;
    if ({flushID, flushEX, flushMEM, stallIF} !== 4'b1110 || flushCnt !== 4'd0 || obs_vec !== exp_vec) begin
      n_err++; $display("FAIL redirect_flush: got %h expected %h", obs_vec, exp_vec);
    end
    tick();
    set_idle();
    eval_cycle();
    n_cmp++;
    if (flushCnt !== 4'd1 || flushMEM !== 1'b0 || obs_vec !== exp_vec) begin
      n_err++; $display("FAIL redirect_count: got %h expected %h", obs_vec, exp_vec);
    end
    tick();
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      dmemReq = 1; dmemReady = 0;
      eval_cycle();
      n_cmp++;
      if ({stallIF, freeze, killWB} !== 3'b111 || obs_vec !== exp_vec) begin
        n_err++; $display("FAIL mem_wait_%0d: got %h expected %h", i, obs_vec, exp_vec);
      end
      tick();
    end
    dmemReady = 1;
    eval_cycle();
    n_cmp++;
    if ({stallIF, freeze, killWB} !== 3'b000 || obs_vec !== exp_vec) begin
      n_err++; $display("FAIL mem_ready: got %h expected %h", obs_vec, exp_vec);
    end
    tick();
    set_idle();
    eval_cycle();
    n_cmp++;
    if (stallCnt !== 4'd3 || obs_vec !== exp_vec) begin
      n_err++; $display("FAIL mem_wait_count: got %0d expected 3", stallCnt);
    end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      dmemReq = (i < 6); dmemReady = 0;
      eval_cycle();
      n_cmp++;
      if (mem_err !== (i >= 4) || stallIF !== 1'b1 || obs_vec !== exp_vec) begin
        n_err++; $display("FAIL timeout_%0d: got %h expected %h", i, obs_vec, exp_vec);
      end
      tick();
    end
    set_idle(); rst = 1;
    eval_cycle();
    n_cmp++;
    if (stallIF !== 1'b0 || obs_vec !== exp_vec) begin
      n_err++; $display("FAIL timeout_in_reset: got %h expected %h", obs_vec, exp_vec);
    end
    tick();
    rst = 0;
    eval_cycle();
    n_cmp++;
    if ({mem_err, stallIF} !== 2'b00 || stallCnt !== 4'd0 || flushCnt !== 4'd0 || obs_vec !== exp_vec) begin
      n_err++; $display("FAIL timeout_cleared: got %h expected %h", obs_vec, exp_vec);
    end
    tick();
  endtask

  task automatic test_redirect_during_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      PCsrc = 2'b10; dmemReq = 1; dmemReady = (i == 2);
      eval_cycle();
      n_cmp++;
      if ({flushID, flushEX, flushMEM} !== ((i == 2) ? 3'b111 : 3'b000) || obs_vec !== exp_vec) begin
        n_err++; $display("FAIL redir_wait_%0d: got %h expected %h", i, obs_vec, exp_vec);
      end
      tick();
    end
    set_idle();
    eval_cycle();
    n_cmp++;
    if (flushCnt !== 4'd1 || stallCnt !== 4'd2 || obs_vec !== exp_vec) begin
      n_err++; $display("FAIL redir_wait_count: got %h expected %h", obs_vec, exp_vec);
    end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 2 * CMAX + 4; i++) begin
      set_idle();
      if (i < CMAX + 2) begin MemRead_EX = 1; rd_EX = 4; rs2_ID = 4; useRs2_ID = 1; end
      else PCsrc = 2'b11;
      eval_cycle(); tick();
    end
    set_idle();
    eval_cycle();
    n_cmp++;
    if (stallCnt !== 4'(CMAX) || flushCnt !== 4'(CMAX) || obs_vec !== exp_vec) begin
      n_err++; $display("FAIL saturation: got %h expected %h", obs_vec, exp_vec);
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      rs1_ID = 5'($urandom_range(0, 3)); rs2_ID = 5'($urandom_range(0, 3));
      rs1_EX = 5'($urandom_range(0, 3)); rs2_EX = 5'($urandom_range(0, 3));
      rd_EX = 5'($urandom_range(0, 3)); rd_MEM = 5'($urandom_range(0, 3));
      rd_WB = 5'($urandom_range(0, 3));
      useRs1_ID = 1'($urandom); useRs2_ID = 1'($urandom);
      MemRead_EX = 1'($urandom); RegWrite_MEM = 1'($urandom); RegWrite_WB = 1'($urandom);
      PCsrc = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      dmemReq = 1'($urandom);
      dmemReady = ($urandom_range(0, 3) != 0);
      eval_cycle();
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_err++; $display("FAIL random_%0d: got %h expected %h", i, obs_vec, exp_vec);
      end
      tick();
    end
  endtask

  initial begin
    set_idle();
    #1;
    test_reset();
    test_load_use();
    test_forward_priority();
    test_redirect();
    test_mem_wait();
    test_timeout();
    test_redirect_during_wait();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
